// File: rtl/cacheflush_pkg.sv
// Shared types for the cache flush sequencer.
package cacheflush_pkg;

   typedef enum logic [2:0] {IDLE, ADR, CHECK, WB, CLEAR, DONE} statetype;

endpackage

// File: rtl/flushcounter.sv
// Combined {set, way} walk counter; way is the low field so it is the inner loop.
module flushcounter #(
   parameter int NUMWAYS  = 4,
   parameter int NUMLINES = 128,
   localparam int SETLEN     = $clog2(NUMLINES),
   localparam int LOGNUMWAYS = $clog2(NUMWAYS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_i,
   input  logic                  en_i,
   output logic [SETLEN-1:0]     set_o,
   output logic [LOGNUMWAYS-1:0] way_o,
   output logic                  last_o
);

   localparam int CNTLEN = SETLEN + LOGNUMWAYS;

   logic [CNTLEN-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)                 cnt_d = '0;
      else if (en_i && !last_o)    cnt_d = cnt_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // Both dimensions are powers of two, so the last pair is the all-ones count.
   assign last_o = &cnt_q;
   assign set_o  = cnt_q[CNTLEN-1:LOGNUMWAYS];
   assign way_o  = cnt_q[LOGNUMWAYS-1:0];

endmodule

// File: rtl/cacheflushfsm.sv
// Flush/invalidate sequencer: walks every (set, way), writes back dirty lines, strobes clears.
module cacheflushfsm
   import cacheflush_pkg::*;
#(
   parameter int NUMWAYS  = 4,
   parameter int NUMLINES = 128,
   localparam int SETLEN     = $clog2(NUMLINES),
   localparam int LOGNUMWAYS = $clog2(NUMWAYS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              FlushStart,
   input  logic              FlushInvalidate,
   input  logic              LineValid,
   input  logic              LineDirty,
   input  logic              WBAck,
   output logic              SelFlush,
   output logic [SETLEN-1:0] FlushAdr,
   output logic [NUMWAYS-1:0] FlushWay,
   output logic              WBReq,
   output logic              ClearDirty,
   output logic              ClearValid,
   output logic              FlushBusy,
   output logic              FlushDone
);

   statetype state_q, state_d;
   logic     mode_q, mode_d;
   logic     dirty_q, dirty_d;
   logic     cnt_clr, cnt_en, cnt_last;
   logic [LOGNUMWAYS-1:0] way_idx;
   logic [NUMWAYS-1:0]    way_dec;

   flushcounter #(.NUMWAYS(NUMWAYS), .NUMLINES(NUMLINES)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear_i (cnt_clr),
      .en_i    (cnt_en),
      .set_o   (FlushAdr),
      .way_o   (way_idx),
      .last_o  (cnt_last)
   );

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      dirty_d = dirty_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      unique case (state_q)
         IDLE: if (FlushStart) begin
            mode_d  = FlushInvalidate;
            dirty_d = 1'b0;
            cnt_clr = 1'b1;
            state_d = ADR;
         end
         ADR:  state_d = CHECK;
         CHECK: begin
            // A dirty bit on an invalid line is stale and treated as clean.
            dirty_d = LineDirty & LineValid;
            if (LineDirty && LineValid)      state_d = WB;
            else if (mode_q && LineValid)    state_d = CLEAR;
            else begin
               cnt_en  = 1'b1;
               state_d = cnt_last ? DONE : ADR;
            end
         end
         WB:   if (WBAck) state_d = CLEAR;
         CLEAR: begin
            cnt_en  = 1'b1;
            state_d = cnt_last ? DONE : ADR;
         end
         DONE: begin
            cnt_clr = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         dirty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         dirty_q <= dirty_d;
      end
   end

   always_comb begin
      way_dec = '0;
      way_dec[way_idx] = 1'b1;
   end

   assign SelFlush   = (state_q != IDLE);
   assign FlushBusy  = (state_q != IDLE);
   assign FlushWay   = SelFlush ? way_dec : '0;
   assign WBReq      = (state_q == WB);
   assign ClearDirty = (state_q == CLEAR) && dirty_q;
   assign ClearValid = (state_q == CLEAR) && mode_q;
   assign FlushDone  = (state_q == DONE);

endmodule

// File: tb/tb_cacheflushfsm.sv
// Directed bench for cacheflushfsm with a 4-set, 2-way line-state model.
module tb_cacheflushfsm;

   localparam int NW = 2;
   localparam int NL = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       FlushStart, FlushInvalidate, LineValid, LineDirty, WBAck;
   logic       SelFlush, WBReq, ClearDirty, ClearValid, FlushBusy, FlushDone;
   logic [1:0] FlushAdr;
   logic [1:0] FlushWay;

   logic valid_a [8];
   logic dirty_a [8];

   int compared = 0;
   int mismatched = 0;

   int r_len, r_wb_cyc, r_wb_cnt, r_cd, r_cv, r_done, r_unstable;
   logic [2:0] cv_q [$];
   logic [3:0] wb_at;

   cacheflushfsm #(.NUMWAYS(NW), .NUMLINES(NL)) dut (
      .clk             (clk),
      .reset           (reset),
      .FlushStart      (FlushStart),
      .FlushInvalidate (FlushInvalidate),
      .LineValid       (LineValid),
      .LineDirty       (LineDirty),
      .WBAck           (WBAck),
      .SelFlush        (SelFlush),
      .FlushAdr        (FlushAdr),
      .FlushWay        (FlushWay),
      .WBReq           (WBReq),
      .ClearDirty      (ClearDirty),
      .ClearValid      (ClearValid),
      .FlushBusy       (FlushBusy),
      .FlushDone       (FlushDone)
   );

   always #5 clk = ~clk;

   // Line-state arrays addressed by the flush address/way.
   always_comb begin
      LineValid = valid_a[{FlushAdr, FlushWay[1]}];
      LineDirty = dirty_a[{FlushAdr, FlushWay[1]}];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic v, input logic d);
      for (int i = 0; i < 8; i++) begin
         valid_a[i] = v;
         dirty_a[i] = d;
      end
   endtask

   task automatic start_flush(input logic inv);
      FlushInvalidate = inv;
      FlushStart = 1'b1;
      cyc();
      FlushStart = 1'b0;
      FlushInvalidate = 1'b0;
   endtask

   // ack_delay < 0 ties WBAck high for the whole run.
   task automatic run_to_done(input int ack_delay, input bit mid_start, input bit spur);
      int n, wait_cnt;
      logic prev_req;
      logic [3:0] prev_at;
      r_len = 0; r_wb_cyc = 0; r_wb_cnt = 0; r_cd = 0; r_cv = 0; r_done = 0; r_unstable = 0;
      cv_q.delete();
      wait_cnt = 0;
      prev_req = 1'b0;
      prev_at = '0;
      n = 1;
      while (n < 300 && !(r_len != 0 && n > r_len + 4)) begin
         if (FlushDone) begin
            r_done++;
            if (r_len == 0) r_len = n;
         end
         if (WBReq) begin
            r_wb_cyc++;
            if (!prev_req) r_wb_cnt++;
            if (prev_req && prev_at != {FlushAdr, FlushWay}) r_unstable++;
            wb_at = {FlushAdr, FlushWay};
         end
         if (ClearDirty) r_cd++;
         if (ClearValid) begin
            r_cv++;
            cv_q.push_back({FlushAdr, FlushWay[1]});
         end
         prev_req = WBReq;
         prev_at = {FlushAdr, FlushWay};
         if (ack_delay < 0) WBAck = 1'b1;
         else if (WBReq) begin
            WBAck = (wait_cnt == ack_delay);
            wait_cnt++;
         end else begin
            WBAck = spur && (n <= 2);
            wait_cnt = 0;
         end
         FlushStart = mid_start && (n == 6);
         cyc();
         n++;
      end
      WBAck = 1'b0;
      FlushStart = 1'b0;
      check("done_within_budget", 32'(r_len != 0), 32'd1);
   endtask

   initial begin
      reset = 1'b0;
      FlushStart = 1'b0;
      FlushInvalidate = 1'b0;
      WBAck = 1'b0;
      fill(1'b0, 1'b0);
      #12;
      check("rst_outputs", {SelFlush, FlushAdr, FlushWay, WBReq, ClearDirty, ClearValid, FlushBusy, FlushDone}, 32'd0);
      cyc();
      reset = 1'b1;
      cyc();

      // Spurious ack in IDLE leaves the sequencer idle.
      WBAck = 1'b1;
      cyc();
      WBAck = 1'b0;
      check("idle_spur_ack_busy", {SelFlush, FlushBusy}, 32'd0);

      // All clean: (set, way) walk, two cycles per line, done at cycle 17.
      fill(1'b1, 1'b0);
      start_flush(1'b0);
      for (int c = 1; c <= 16; c++) begin
         int line;
         line = (c - 1) / 2;
         check($sformatf("walk_adr_c%0d", c), FlushAdr, 32'(line / 2));
         check($sformatf("walk_way_c%0d", c), FlushWay, (line % 2) ? 32'd2 : 32'd1);
         check($sformatf("walk_quiet_c%0d", c), {WBReq, ClearDirty, ClearValid, FlushDone}, 32'd0);
         check($sformatf("walk_busy_c%0d", c), {SelFlush, FlushBusy}, 32'd3);
         cyc();
      end
      check("walk_done_c17", FlushDone, 32'd1);
      cyc();
      check("walk_idle_after", {FlushDone, FlushBusy, SelFlush, FlushWay}, 32'd0);

      // Only (2, way1) dirty with ack after three wait cycles.
      fill(1'b1, 1'b0);
      dirty_a[5] = 1'b1;
      start_flush(1'b0);
      run_to_done(3, 1'b0, 1'b0);
      check("dirty1_len", r_len, 32'd22);
      check("dirty1_wbreq_cycles", r_wb_cyc, 32'd4);
      check("dirty1_wb_at", wb_at, 32'b1010);
      check("dirty1_cleardirty", r_cd, 32'd1);
      check("dirty1_stable", r_unstable, 32'd0);
      check("dirty1_clearvalid", r_cv, 32'd0);

      // Invalidate mode, all valid and clean.
      fill(1'b1, 1'b0);
      start_flush(1'b1);
      run_to_done(0, 1'b0, 1'b0);
      check("inv_len", r_len, 32'd25);
      check("inv_clearvalid_cnt", r_cv, 32'd8);
      check("inv_cleardirty_cnt", r_cd, 32'd0);
      check("inv_no_wb", r_wb_cyc, 32'd0);
      for (int i = 0; i < 8; i++) begin
         logic [2:0] got;
         got = (i < cv_q.size()) ? cv_q[i] : 3'h7;
         if (i == 7 && cv_q.size() < 8) got = 3'h0;
         check($sformatf("inv_order_%0d", i), got, 32'(i));
      end

      // Every line dirty, ack tied high, FlushStart pulsed mid-flush.
      fill(1'b1, 1'b1);
      start_flush(1'b0);
      run_to_done(-1, 1'b1, 1'b0);
      check("alldirty_len", r_len, 32'd33);
      check("alldirty_wb_cnt", r_wb_cnt, 32'd8);
      check("alldirty_wb_cycles", r_wb_cyc, 32'd8);
      check("alldirty_cleardirty", r_cd, 32'd8);
      check("alldirty_one_done", r_done, 32'd1);
      check("alldirty_idle_after", FlushBusy, 32'd0);

      // Dirty-but-invalid lines and a spurious ack in ADR/CHECK of line 0.
      fill(1'b0, 1'b1);
      start_flush(1'b1);
      run_to_done(0, 1'b0, 1'b1);
      check("invdirty_len", r_len, 32'd17);
      check("invdirty_no_wb", r_wb_cyc, 32'd0);
      check("invdirty_no_clear", r_cd + r_cv, 32'd0);

      // Reset while in WB aborts the flush with no completion pulse.
      fill(1'b1, 1'b0);
      dirty_a[0] = 1'b1;
      start_flush(1'b0);
      cyc();
      cyc();
      check("abort_in_wb", WBReq, 32'd1);
      reset = 1'b0;
      #1;
      check("abort_outputs", {SelFlush, FlushAdr, FlushWay, WBReq, ClearDirty, ClearValid, FlushBusy, FlushDone}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check($sformatf("abort_no_done_%0d", i), {FlushDone, FlushBusy}, 32'd0);
      end
      reset = 1'b1;
      cyc();
      check("abort_still_idle", {FlushDone, FlushBusy}, 32'd0);
      dirty_a[0] = 1'b0;
      start_flush(1'b0);
      check("restart_adr", FlushAdr, 32'd0);
      check("restart_way", FlushWay, 32'd1);
      run_to_done(0, 1'b0, 1'b0);
      check("restart_len", r_len, 32'd17);
      check("restart_one_done", r_done, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
